// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port arbiter sharing one simple dual-port RAM
// Optional feature macro: RAM_ARB_COLLISION_STATS_EN (same-address deferral counter)
module ram_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_writeData,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_readData,
  output logic [DATA_WIDTH-1:0]            resp_readData_1,
  output logic [NUM_REQ-1:0]               resp_sel_1,
  output logic                             ram_writeEnable_0,
  output logic                             ram_writeEnable_1,
  output logic [ADDRESS_WIDTH-1:0]         ram_address_0,
  output logic [ADDRESS_WIDTH-1:0]         ram_address_1,
  output logic [DATA_WIDTH-1:0]            ram_writeData_0,
  output logic [DATA_WIDTH-1:0]            ram_writeData_1,
  input  logic [DATA_WIDTH-1:0]            ram_readData_0,
  input  logic [DATA_WIDTH-1:0]            ram_readData_1,
  output logic [15:0]                      collision_count
);
  localparam int REQ_BITS = $clog2(NUM_REQ);
  localparam logic [REQ_BITS:0] NUM_REQ_W = (REQ_BITS+1)'(NUM_REQ);

  logic [ADDRESS_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    wdata_arr [NUM_REQ];
  logic [REQ_BITS-1:0]      rr_ptr;
  logic [REQ_BITS-1:0]      a_idx, b_idx;
  logic                     found_a, found_b;
  logic                     grant_a, grant_b;
  logic                     owner_valid_0, owner_valid_1;
  logic [REQ_BITS-1:0]      owner_id_0, owner_id_1;

  // Modulo-NUM_REQ increment that also works for non-power-of-two NUM_REQ
  function automatic logic [REQ_BITS-1:0] wrap_add(input logic [REQ_BITS-1:0] base,
                                                   input logic [REQ_BITS:0]   off);
    logic [REQ_BITS:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    return sum[REQ_BITS-1:0];
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign wdata_arr[g] = req_writeData[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin scan: A is the first valid requester, B the next one whose address differs from A's
  always_comb begin
    logic [REQ_BITS-1:0] idx;
    found_a = 1'b0;
    found_b = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_add(rr_ptr, (REQ_BITS+1)'(k));
      if (req_valid[idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_idx   = idx;
        end else if (!found_b && (addr_arr[idx] != addr_arr[a_idx])) begin
          found_b = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

  // Grants are suppressed entirely while reset is held low
  assign grant_a = found_a & reset;
  assign grant_b = found_b & reset;

  // One-hot-or-two grant vector back to the requesters
  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[a_idx] = 1'b1;
    if (grant_b) req_ready[b_idx] = 1'b1;
  end

  assign ram_writeEnable_0 = grant_a & req_write[a_idx];
  assign ram_address_0     = grant_a ? addr_arr[a_idx]  : '0;
  assign ram_writeData_0   = grant_a ? wdata_arr[a_idx] : '0;
  assign ram_writeEnable_1 = grant_b & req_write[b_idx];
  assign ram_address_1     = grant_b ? addr_arr[b_idx]  : '0;
  assign ram_writeData_1   = grant_b ? wdata_arr[b_idx] : '0;

  // Advance the pointer past the last winner and remember who owns each port's response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      owner_valid_0 <= 1'b0;
      owner_valid_1 <= 1'b0;
      owner_id_0    <= '0;
      owner_id_1    <= '0;
    end else begin
      owner_valid_0 <= grant_a;
      owner_valid_1 <= grant_b;
      owner_id_0    <= a_idx;
      owner_id_1    <= b_idx;
      if (grant_a) rr_ptr <= wrap_add(grant_b ? b_idx : a_idx, (REQ_BITS+1)'(1));
    end
  end

  // Steer the RAM read ports back to their owners one cycle after the grant
  always_comb begin
    resp_valid = '0;
    resp_sel_1 = '0;
    if (owner_valid_0) resp_valid[owner_id_0] = 1'b1;
    if (owner_valid_1) begin
      resp_valid[owner_id_1] = 1'b1;
      resp_sel_1[owner_id_1] = 1'b1;
    end
  end

  assign resp_readData   = ram_readData_0;
  assign resp_readData_1 = ram_readData_1;

`ifdef RAM_ARB_COLLISION_STATS_EN
  logic        deferral;
  logic [15:0] coll_q;

  // A cycle has a deferral when any other valid requester shares A's address
  always_comb begin
    deferral = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found_a && req_valid[i] && (REQ_BITS'(i) != a_idx) && (addr_arr[i] == addr_arr[a_idx]))
        deferral = 1'b1;
    end
  end

  // Saturating count of cycles that deferred at least one request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) coll_q <= '0;
    else if (deferral && (coll_q != 16'hFFFF)) coll_q <= coll_q + 16'd1;
  end

  assign collision_count = coll_q;
`else
  assign collision_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed scoreboard bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clock;
  logic            reset;
  logic [N-1:0]    rv, rw;
  logic [N*AW-1:0] ra;
  logic [N*DW-1:0] rd;
  logic [N-1:0]    req_ready, resp_valid, resp_sel_1;
  logic [DW-1:0]   resp_readData, resp_readData_1;
  logic            we0, we1;
  logic [AW-1:0]   a0, a1;
  logic [DW-1:0]   wd0, wd1, rd0, rd1;
  logic [15:0]     collision_count;

  ram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(rv), .req_write(rw), .req_address(ra), .req_writeData(rd),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_readData(resp_readData), .resp_readData_1(resp_readData_1), .resp_sel_1(resp_sel_1),
    .ram_writeEnable_0(we0), .ram_writeEnable_1(we1),
    .ram_address_0(a0), .ram_address_1(a1),
    .ram_writeData_0(wd0), .ram_writeData_1(wd1),
    .ram_readData_0(rd0), .ram_readData_1(rd1),
    .collision_count(collision_count)
  );

  // Behavioural simple dual-port RAM: one-cycle read, write echoes the written word
  logic [DW-1:0] mem [256];
  always @(posedge clock) begin
    if (we0) begin mem[a0] <= wd0; rd0 <= wd0; end else rd0 <= mem[a0];
    if (we1) begin mem[a1] <= wd1; rd1 <= wd1; end else rd1 <= mem[a1];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int id; int port; logic [DW-1:0] data; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_mem [256];
  int            compared = 0;
  int            mismatched = 0;
  int            grant_cnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    rv[i] = 1'b1;
    rw[i] = w;
    ra[i*AW +: AW] = addr;
    rd[i*DW +: DW] = data;
  endtask

  task automatic push(input int i, input int port);
    exp_t e;
    logic [AW-1:0] addr;
    addr   = ra[i*AW +: AW];
    e.id   = i;
    e.port = port;
    e.data = rw[i] ? rd[i*DW +: DW] : ref_mem[addr];
    sb.push_back(e);
    if (port == 0) begin
      check("ram_address_0", a0, addr);
      check("ram_writeEnable_0", we0, rw[i]);
    end else begin
      check("ram_address_1", a1, addr);
      check("ram_writeEnable_1", we1, rw[i]);
    end
  endtask

  task automatic pop_check();
    logic [N-1:0] ev, es;
    ev = '0;
    es = '0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      ev[e.id] = 1'b1;
      if (e.port == 1) begin
        es[e.id] = 1'b1;
        check("resp_readData_1", resp_readData_1, e.data);
      end else begin
        check("resp_readData", resp_readData, e.data);
      end
    end
    check("resp_valid", resp_valid, ev);
    check("resp_sel_1", resp_sel_1, es);
  endtask

  // Called at posedge+1: checks grants mid-cycle, then responses just after the next edge
  task automatic step(input int a, input int b, input bit hold);
    logic [N-1:0] er;
    #3;
    er = '0;
    if (a >= 0) er[a] = 1'b1;
    if (b >= 0) er[b] = 1'b1;
    check("req_ready", req_ready, er);
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_cnt[i]++;
    if (a >= 0) push(a, 0);
    if (b >= 0) push(b, 1);
    else begin
      check("port1_idle_we", we1, 1'b0);
      check("port1_idle_addr", a1, '0);
      check("port1_idle_data", wd1, '0);
    end
    if (a >= 0 && rw[a]) ref_mem[ra[a*AW +: AW]] = rd[a*DW +: DW];
    if (b >= 0 && rw[b]) ref_mem[ra[b*AW +: AW]] = rd[b*DW +: DW];
    @(posedge clock);
    #1;
    pop_check();
    if (!hold) begin
      if (a >= 0) rv[a] = 1'b0;
      if (b >= 0) rv[b] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
    reset = 1'b0;
    rv = '0; rw = '0; ra = '0; rd = '0;

    // 1: grants gated during reset, first grants after release are {0,1} then {2,3}
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(20 + i), 32'h1000 + i);
    #2;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_we0", we0, 1'b0);
    check("reset_we1", we1, 1'b0);
    check("reset_resp_valid", resp_valid, 4'b0000);
    check("reset_resp_sel_1", resp_sel_1, 4'b0000);
    check("reset_collision", collision_count, 16'h0000);
    @(posedge clock); @(posedge clock); #1;
    check("reset_ready_held", req_ready, 4'b0000);
    reset = 1'b1;
    step(0, 1, 1'b0);
    step(2, 3, 1'b0);

    // 2: write then read-back through a different requester
    set_req(0, 1'b1, 8'd5, 32'hA5A5_0001);
    step(0, -1, 1'b0);
    set_req(2, 1'b0, 8'd5, 32'h0);
    step(2, -1, 1'b0);

    // 3: same-address write/write, later requester deferred one cycle
    set_req(3, 1'b0, 8'd20, 32'h0);
    step(3, -1, 1'b0);
    set_req(1, 1'b1, 8'd9, 32'h1111_0009);
    set_req(3, 1'b1, 8'd9, 32'h3333_0009);
    step(1, -1, 1'b0);
`ifdef RAM_ARB_COLLISION_STATS_EN
    check("collision_ww", collision_count, 16'd1);
`else
    check("collision_ww", collision_count, 16'd0);
`endif
    step(3, -1, 1'b0);
    set_req(0, 1'b0, 8'd9, 32'h0);
    step(0, -1, 1'b0);

    // 4: four held requests, distinct addresses, eight cycles of rotation
    set_req(3, 1'b0, 8'd20, 32'h0);
    step(3, -1, 1'b0);
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(20 + i), 32'h0);
    for (int c = 0; c < 8; c++) step((c % 2 == 0) ? 0 : 2, (c % 2 == 0) ? 1 : 3, 1'b1);
    rv = '0;
    for (int i = 0; i < N; i++) check($sformatf("grant_cnt_%0d", i), grant_cnt[i], 4);
`ifdef RAM_ARB_COLLISION_STATS_EN
    check("collision_rr", collision_count, 16'd1);
`else
    check("collision_rr", collision_count, 16'd0);
`endif

    // 5: same-address write/read, reader deferred and sees the new value
    set_req(1, 1'b1, 8'd3, 32'hBEEF_0005);
    set_req(2, 1'b0, 8'd3, 32'h0);
    step(1, -1, 1'b0);
    step(2, -1, 1'b0);
`ifdef RAM_ARB_COLLISION_STATS_EN
    check("collision_wr", collision_count, 16'd2);
`else
    check("collision_wr", collision_count, 16'd0);
`endif

    // 6: reset right after a grant drops the response; the write still lands
    set_req(0, 1'b1, 8'd7, 32'h0000_0077);
    #3;
    check("pre_reset_ready", req_ready, 4'b0001);
    ref_mem[7] = 32'h0000_0077;
    @(posedge clock); #1;
    reset = 1'b0;
    rv = '0;
    #1;
    check("midreset_resp_valid", resp_valid, 4'b0000);
    check("midreset_resp_sel_1", resp_sel_1, 4'b0000);
    check("midreset_collision", collision_count, 16'h0000);
    @(posedge clock); #1;
    check("midreset_resp_valid_2", resp_valid, 4'b0000);
    check("midreset_we0", we0, 1'b0);
    reset = 1'b1;
    set_req(0, 1'b0, 8'd7, 32'h0);
    set_req(1, 1'b0, 8'd20, 32'h0);
    set_req(2, 1'b0, 8'd21, 32'h0);
    set_req(3, 1'b0, 8'd22, 32'h0);
    step(0, 1, 1'b0);
    step(2, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
